accumulator_alu: RTL

ACCUMULATOR_ALU -- requirements
Module: accumulator_alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/shift_add_mul.sv | 49 ++++
 rtl/accumulator_alu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for accumulator_alu: opcode encoding, controller states
// and the default data width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_LDB = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: operands latched on load, one partial
// product accumulated per step, WIDTH steps per multiplication.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product_next
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // Exposing the next product lets the controller capture the final result
  // on the same edge as the last iteration.
  assign product_next = mplier[0] ? (product + mcand) : product;
  assign last         = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else if (load) begin
      product <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      count   <= '0;
    end else if (step) begin
      product <= product_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + CW'(1);
    end
  end

endmodule

// File: rtl/accumulator_alu.sv
// Accumulator ALU with registered result and flags. The multi-cycle MUL
// operation is only built when ACCUMULATOR_ALU_MUL_EN is defined.
module accumulator_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic             Carry,
  output logic             Zero
);

  logic [WIDTH-1:0] res_data;
  logic             res_carry;

  // Single-cycle results; an unbuilt MUL falls through as a no-op that
  // keeps Data and clears Carry.
  always_comb begin
    res_data  = Data;
    res_carry = 1'b0;
    case (op_e'(Op))
      OP_ADD: {res_carry, res_data} = {1'b0, A} + {1'b0, B};
      OP_SUB: begin
        res_data  = A - B;
        res_carry = (A < B);
      end
      OP_AND: res_data = A & B;
      OP_OR:  res_data = A | B;
      OP_XOR: res_data = A ^ B;
      OP_SHL: begin
        res_data  = {A[WIDTH-2:0], 1'b0};
        res_carry = A[WIDTH-1];
      end
      OP_LDB: res_data = B;
      OP_MUL: ;
      default: ;
    endcase
  end

`ifdef ACCUMULATOR_ALU_MUL_EN
  state_e             state;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_load = (state == ST_IDLE) && Start && (op_e'(Op) == OP_MUL);
  assign mul_step = (state == ST_MUL);

  shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk         (clk),
    .reset       (Reset),
    .load        (mul_load),
    .step        (mul_step),
    .a           (A),
    .b           (B),
    .last        (mul_last),
    .product_next(mul_product)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      Data  <= '0;
      Carry <= 1'b0;
      Zero  <= 1'b1;
      Done  <= 1'b0;
      Busy  <= 1'b0;
      state <= ST_IDLE;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (op_e'(Op) == OP_MUL) begin
              state <= ST_MUL;
              Busy  <= 1'b1;
            end else begin
              Data  <= res_data;
              Carry <= res_carry;
              Zero  <= (res_data == '0);
              Done  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            Data  <= mul_product[WIDTH-1:0];
            Carry <= |mul_product[2*WIDTH-1:WIDTH];
            Zero  <= (mul_product[WIDTH-1:0] == '0);
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (Reset) begin
      Data  <= '0;
      Carry <= 1'b0;
      Zero  <= 1'b1;
      Done  <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Start) begin
        Data  <= res_data;
        Carry <= res_carry;
        Zero  <= (res_data == '0);
        Done  <= 1'b1;
      end
    end
  end
`endif

endmodule
